// File: rtl/m_issue_unit.sv
// ============================================================================
// m_issue_unit
//   Decodes RV M-extension instructions into a one-entry multiply/divide command
//   register and tracks how many divides are still in flight.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module m_issue_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int DIV_MAX = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  input  logic             div_done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             mult_on_o,
  output logic             div_on_o,
  output logic             signed_A_o,
  output logic             signed_B_o,
  output logic             upper_rem_o,
  output logic             word_o,
  output logic             div_zero_o,
  output logic             div_ovf_o,
  output logic [XLEN-1:0]  rs1_o,
  output logic [XLEN-1:0]  rs2_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o,
  output logic             div_busy_o
);

  localparam int c_cnt_w  = $clog2(DIV_MAX + 1);
  localparam int c_cnt_xw = c_cnt_w + 1;
  localparam logic [c_cnt_w-1:0] c_div_max = c_cnt_w'(DIV_MAX);
  localparam logic [XLEN-1:0] c_min_neg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [0:0] c_st_empty = 1'b0;
  localparam logic [0:0] c_st_full  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               mult_q, div_q, sa_q, sb_q, ur_q, word_q, dz_q, dov_q, ill_q;
  logic [XLEN-1:0]    rs1_q, rs2_q;
  logic [TAG_W-1:0]   tag_q;

  logic w_is_base, w_is_word, w_is_m, w_word_ill, w_is_div;
  logic w_sa, w_sb, w_ur, w_rs2_zero, w_rs1_min, w_rs2_ones, w_dz, w_dov;
  logic w_div_busy, w_accept, w_load, w_pop, w_inc, w_flush_div;
  logic [c_cnt_xw-1:0] w_cnt_up, w_cnt_dn;

  assign w_is_base  = (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001);
  assign w_is_word  = (XLEN == 64) && (opcode_i == 7'b0111011) && (funct7_i == 7'b0000001);
  assign w_is_m     = w_is_base || w_is_word;
  // Word forms of the high multiplies do not exist in the ISA.
  assign w_word_ill = w_is_word && (funct3_i inside {3'b001, 3'b010, 3'b011});
  assign w_is_div   = w_is_m && funct3_i[2];

  always_comb begin
    {w_sa, w_sb, w_ur} = 3'b000;
    case (funct3_i)
      3'b000:  {w_sa, w_sb, w_ur} = 3'b000;
      3'b001:  {w_sa, w_sb, w_ur} = 3'b111;
      3'b010:  {w_sa, w_sb, w_ur} = 3'b101;
      3'b011:  {w_sa, w_sb, w_ur} = 3'b001;
      3'b100:  {w_sa, w_sb, w_ur} = 3'b110;
      3'b101:  {w_sa, w_sb, w_ur} = 3'b000;
      3'b110:  {w_sa, w_sb, w_ur} = 3'b111;
      default: {w_sa, w_sb, w_ur} = 3'b001;
    endcase
  end

  assign w_rs2_zero = w_is_word ? (rs2_i[31:0] == 32'd0) : (rs2_i == '0);
  assign w_rs1_min  = w_is_word ? (rs1_i[31:0] == 32'h8000_0000) : (rs1_i == c_min_neg);
  assign w_rs2_ones = w_is_word ? (&rs2_i[31:0]) : (&rs2_i);
  assign w_dz       = w_is_div && w_rs2_zero;
  assign w_dov      = w_is_div && (funct3_i == 3'b100 || funct3_i == 3'b110)
                      && w_rs1_min && w_rs2_ones;

  assign w_div_busy  = (cnt_q == c_div_max);
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_load      = w_accept && w_is_m && !w_word_ill;
  assign w_pop       = (state_q == c_st_full) && out_ready_i;
  assign w_inc       = w_load && w_is_div;
  assign w_flush_div = flush_i && (state_q == c_st_full) && div_q;

  // Wider arithmetic so a completion or flush at zero saturates instead of wrapping.
  assign w_cnt_up = {1'b0, cnt_q} + c_cnt_xw'(w_inc);
  assign w_cnt_dn = c_cnt_xw'(div_done_i) + c_cnt_xw'(w_flush_div);
  assign cnt_d    = (w_cnt_up < w_cnt_dn) ? '0 : c_cnt_w'(w_cnt_up - w_cnt_dn);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= c_st_empty;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i)     state_d = c_st_empty;
    else if (w_load) state_d = c_st_full;
    else if (w_pop)  state_d = c_st_empty;
  end

  always_comb begin
    out_valid_o = (state_q == c_st_full);
    in_ready_o  = !rst_i && !flush_i && ((state_q == c_st_empty) || out_ready_i)
                  && !(w_is_div && w_div_busy);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {mult_q, div_q, sa_q, sb_q, ur_q, word_q, dz_q, dov_q} <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      tag_q <= '0;
      ill_q <= 1'b0;
    end else begin
      ill_q <= w_accept && w_word_ill;
      if (w_load) begin
        mult_q <= !funct3_i[2];
        div_q  <= funct3_i[2];
        sa_q   <= w_sa;
        sb_q   <= w_sb;
        ur_q   <= w_ur;
        word_q <= w_is_word;
        dz_q   <= w_dz;
        dov_q  <= w_dov;
        rs1_q  <= rs1_i;
        rs2_q  <= rs2_i;
        tag_q  <= tag_i;
      end
    end
  end

  assign mult_on_o   = mult_q;
  assign div_on_o    = div_q;
  assign signed_A_o  = sa_q;
  assign signed_B_o  = sb_q;
  assign upper_rem_o = ur_q;
  assign word_o      = word_q;
  assign div_zero_o  = dz_q;
  assign div_ovf_o   = dov_q;
  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;
  assign tag_o       = tag_q;
  assign illegal_o   = ill_q;
  assign div_busy_o  = w_div_busy;

endmodule

`default_nettype wire

// File: tb/tb_m_issue_unit.sv
// ============================================================================
// tb_m_issue_unit
//   Self-checking bench: directed scenarios plus random traffic against a
//   per-instruction reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_m_issue_unit;
  localparam int DMAX = 2;

  typedef struct packed {
    logic mult, div, a, b, ur, word, dz, dov;
    logic [63:0] rs1, rs2;
    logic [4:0] tag;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, flush, div_done, out_ready, in_valid32, done32;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [63:0] rs1, rs2;
  logic [4:0] tag;

  logic in_ready, out_valid, mult_on, div_on, sa, sb, ur, word, dz, dov, illegal, busy;
  logic [63:0] rs1_o, rs2_o;
  logic [4:0] tag_o;
  cmd_t obs;
  assign obs = {mult_on, div_on, sa, sb, ur, word, dz, dov, rs1_o, rs2_o, tag_o};

  logic in_ready32, out_valid32, mult32, div32, a32, b32, ur32, word32, dz32, dov32, ill32, busy32;
  logic [31:0] rs1o32, rs2o32;
  logic [4:0] tag32;

  m_issue_unit #(.XLEN(64), .TAG_W(5), .DIV_MAX(DMAX)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2),
    .tag_i(tag), .flush_i(flush), .div_done_i(div_done), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .mult_on_o(mult_on), .div_on_o(div_on), .signed_A_o(sa),
    .signed_B_o(sb), .upper_rem_o(ur), .word_o(word), .div_zero_o(dz), .div_ovf_o(dov),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .tag_o(tag_o), .illegal_o(illegal), .div_busy_o(busy));

  m_issue_unit #(.XLEN(32), .TAG_W(5), .DIV_MAX(DMAX)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7), .rs1_i(rs1[31:0]),
    .rs2_i(rs2[31:0]), .tag_i(tag), .flush_i(flush), .div_done_i(done32),
    .out_valid_o(out_valid32), .out_ready_i(out_ready), .mult_on_o(mult32),
    .div_on_o(div32), .signed_A_o(a32), .signed_B_o(b32), .upper_rem_o(ur32),
    .word_o(word32), .div_zero_o(dz32), .div_ovf_o(dov32), .rs1_o(rs1o32),
    .rs2_o(rs2o32), .tag_o(tag32), .illegal_o(ill32), .div_busy_o(busy32));

  int total = 0;
  int bad = 0;

  // Reference model of the 64-bit instance: held command, divides in flight, illegal pulse.
  logic m_full, m_ill;
  int   m_cnt;
  cmd_t m_cmd;

  // 0 = not M, 1 = legal M, 2 = malformed word form
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (f7 != 7'd1) return 0;
    if (op == 7'h33) return 1;
    if (op == 7'h3B) return (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) ? 2 : 1;
    return 0;
  endfunction

  function automatic cmd_t ref_cmd(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    cmd_t r;
    logic [63:0] mask, minv;
    r = '0;
    r.word = (op == 7'h3B);
    r.mult = (f3 < 3'd4);
    r.div  = (f3 >= 3'd4);
    case (f3)
      3'd1, 3'd6: {r.a, r.b, r.ur} = 3'b111;
      3'd2:       {r.a, r.b, r.ur} = 3'b101;
      3'd3, 3'd7: {r.a, r.b, r.ur} = 3'b001;
      3'd4:       {r.a, r.b, r.ur} = 3'b110;
      default:    {r.a, r.b, r.ur} = 3'b000;
    endcase
    mask = r.word ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    minv = r.word ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
    r.dz  = r.div && ((b & mask) == 64'd0);
    r.dov = (f3 == 3'd4 || f3 == 3'd6) && ((a & mask) == minv) && ((b & mask) == mask);
    r.rs1 = a;
    r.rs2 = b;
    r.tag = t;
    return r;
  endfunction

  function automatic logic exp_rdy();
    return !rst && !flush && (!m_full || out_ready) &&
           !(classify(opcode, funct3, funct7) != 0 && funct3[2] && m_cnt == DMAX);
  endfunction

  task automatic model_step();
    logic acc;
    int k, c;
    if (rst) begin
      m_full = 1'b0; m_ill = 1'b0; m_cnt = 0; m_cmd = '0;
    end else begin
      acc = in_valid && exp_rdy();
      k = classify(opcode, funct3, funct7);
      c = m_cnt + ((acc && k == 1 && funct3[2]) ? 1 : 0) - (div_done ? 1 : 0)
          - ((flush && m_full && m_cmd.div) ? 1 : 0);
      m_cnt = (c < 0) ? 0 : c;
      m_ill = acc && (k == 2);
      if (flush) m_full = 1'b0;
      else if (acc && k == 1) begin
        m_full = 1'b1;
        m_cmd = ref_cmd(opcode, funct3, rs1, rs2, tag);
      end else if (m_full && out_ready) m_full = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_valid32 = 0; flush = 0; div_done = 0; done32 = 0; out_ready = 1;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; rs1 = '0; rs2 = '0; tag = '0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] b);
    in_valid = 1; opcode = op; funct3 = f3; funct7 = 7'd1; rs1 = a; rs2 = b;
    tag = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    idle();
    div_done = 1;
    repeat (3) tick();
    div_done = 0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) tick();
    total++;
    if ({out_valid, in_ready, illegal, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {out_valid, in_ready, illegal, busy});
    end
    total++;
    if (obs !== cmd_t'(0)) begin
      bad++; $display("FAIL reset_data: got %h want 0", obs);
    end
    rst = 0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_mulh();
    idle();
    set_instr(7'h33, 3'd1, 64'hFFFF_FFFF, 64'd2);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mulh_ready: got %b want 1", in_ready); end
    tick();
    total++;
    if ({out_valid, mult_on, div_on, sa, sb, ur} !== 6'b110111) begin
      bad++; $display("FAIL mulh_decode: got %b want 110111", {out_valid, mult_on, div_on, sa, sb, ur});
    end
    total++;
    if (obs !== m_cmd) begin bad++; $display("FAIL mulh_cmd: got %h want %h", obs, m_cmd); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    idle();
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom};
      set_instr(7'h33, 3'(i), v, ~v);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || rs1_o !== v || obs !== m_cmd) begin
        bad++; $display("FAIL b2b_load%0d: got %h want %h", i, obs, m_cmd);
      end
    end
    idle();
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_div_special();
    drain();
    set_instr(7'h33, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    total++;
    if ({div_on, dov, dz} !== 3'b110) begin
      bad++; $display("FAIL div_ovf64: got %b want 110", {div_on, dov, dz});
    end
    set_instr(7'h3B, 3'd6, 64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF);
    tick();
    total++;
    if ({word, dov, dz, busy} !== 4'b1101 || obs !== m_cmd) begin
      bad++; $display("FAIL remw_ovf: got %b want 1101", {word, dov, dz, busy});
    end
    drain();
    set_instr(7'h33, 3'd5, 64'd77, 64'd0);
    tick();
    total++;
    if ({dov, dz} !== 2'b01) begin bad++; $display("FAIL divu_zero: got %b want 01", {dov, dz}); end
    set_instr(7'h3B, 3'd5, 64'd5, 64'hABCD_0000_0000_0000);
    tick();
    total++;
    if ({word, dz} !== 2'b11 || obs !== m_cmd) begin
      bad++; $display("FAIL divuw_zero: got %b want 11", {word, dz});
    end
    drain();
  endtask

  task automatic test_div_busy();
    drain();
    set_instr(7'h33, 3'd4, 64'd10, 64'd3);
    tick();
    tick();
    set_instr(7'h33, 3'd4, 64'd11, 64'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({in_ready, busy} !== 2'b01) begin
        bad++; $display("FAIL busy_stall%0d: got %b want 01", i, {in_ready, busy});
      end
      tick();
    end
    div_done = 1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_done_cycle: got %b want 0", in_ready); end
    tick();
    div_done = 0;
    #1;
    total++;
    if ({in_ready, busy} !== 2'b10) begin
      bad++; $display("FAIL busy_release: got %b want 10", {in_ready, busy});
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || rs1_o !== 64'd11 || busy !== 1'b1) begin
      bad++; $display("FAIL busy_accept: got %b/%h want 1/b", out_valid, rs1_o);
    end
    drain();
  endtask

  task automatic test_hold();
    cmd_t snap;
    drain();
    out_ready = 0;
    set_instr(7'h33, 3'd7, 64'h55, 64'h7);
    tick();
    snap = obs;
    set_instr(7'h33, 3'd0, 64'h99, 64'h3);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== snap || obs !== m_cmd) begin
        bad++; $display("FAIL hold%0d: got %b %h want 0 1 %h", i, in_ready, obs, snap);
      end
      tick();
    end
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release: got %b want 1", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b1 || mult_on !== 1'b1 || rs1_o !== 64'h99) begin
      bad++; $display("FAIL hold_newload: got %b %b %h want 1 1 99", out_valid, mult_on, rs1_o);
    end
    idle();
    tick();
  endtask

  task automatic test_illegal();
    idle();
    tick();
    set_instr(7'h3B, 3'd1, 64'd3, 64'd4);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ill_ready: got %b want 1", in_ready); end
    tick();
    idle();
    total++;
    if ({illegal, out_valid} !== 2'b10) begin
      bad++; $display("FAIL ill_pulse: got %b want 10", {illegal, out_valid});
    end
    tick();
    total++;
    if ({illegal, out_valid} !== 2'b00) begin
      bad++; $display("FAIL ill_clear: got %b want 00", {illegal, out_valid});
    end
  endtask

  task automatic test_flush();
    drain();
    set_instr(7'h33, 3'd4, 64'd1, 64'd1);
    tick();
    set_instr(7'h33, 3'd6, 64'd2, 64'd1);
    tick();
    idle();
    out_ready = 0; flush = 1; div_done = 1;
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b011) begin
      bad++; $display("FAIL flush_pre: got %b want 011", {in_ready, out_valid, busy});
    end
    tick();
    flush = 0; div_done = 0; out_ready = 1;
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL flush_post: got %b want 00", {out_valid, busy});
    end
    set_instr(7'h33, 3'd4, 64'd3, 64'd1);
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL flush_cnt1: got %b want 0", busy); end
    set_instr(7'h33, 3'd4, 64'd4, 64'd1);
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL flush_cnt2: got %b want 1", busy); end
    drain();
  endtask

  task automatic test_xlen32();
    idle();
    tick();
    in_valid32 = 1; opcode = 7'h33; funct7 = 7'd1; funct3 = 3'd1;
    rs1 = 64'hFFFF_FFFF; rs2 = 64'd2;
    #1;
    total++;
    if (in_ready32 !== 1'b1) begin bad++; $display("FAIL x32_ready: got %b want 1", in_ready32); end
    tick();
    total++;
    if ({out_valid32, mult32, a32, b32, ur32} !== 5'b11111 || rs1o32 !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL x32_mulh: got %b %h want 11111 ffffffff",
                      {out_valid32, mult32, a32, b32, ur32}, rs1o32);
    end
    funct3 = 3'd4; rs1 = 64'h8000_0000; rs2 = 64'hFFFF_FFFF;
    tick();
    total++;
    if ({div32, dov32, dz32} !== 3'b110) begin
      bad++; $display("FAIL x32_div_ovf: got %b want 110", {div32, dov32, dz32});
    end
    funct3 = 3'd5; rs1 = 64'd9; rs2 = 64'd0;
    tick();
    total++;
    if ({div32, dov32, dz32} !== 3'b101) begin
      bad++; $display("FAIL x32_divu_zero: got %b want 101", {div32, dov32, dz32});
    end
    opcode = 7'h3B; funct3 = 3'd0; done32 = 1;
    #1;
    total++;
    if (in_ready32 !== 1'b1) begin bad++; $display("FAIL x32_word_ready: got %b want 1", in_ready32); end
    tick();
    total++;
    if ({out_valid32, ill32} !== 2'b00) begin
      bad++; $display("FAIL x32_word_drop: got %b want 00", {out_valid32, ill32});
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    int k, r;
    logic exp;
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = (k < 4 || k == 8) ? 7'h33 : (k < 7) ? 7'h3B : 7'($urandom_range(0, 127));
      funct7    = (k == 8) ? 7'($urandom_range(0, 127)) : 7'd1;
      funct3    = 3'($urandom_range(0, 7));
      tag       = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 5);
      rs1 = (r == 0) ? 64'h8000_0000_0000_0000 : (r == 1) ? {32'($urandom), 32'h8000_0000} :
            {32'($urandom), 32'($urandom)};
      r = $urandom_range(0, 5);
      rs2 = (r == 0) ? 64'd0 : (r == 1) ? '1 : (r == 2) ? {32'($urandom), 32'hFFFF_FFFF} :
            (r == 3) ? {32'($urandom), 32'h0} : {32'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 24) == 0);
      div_done  = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      #1;
      exp = exp_rdy();
      total++;
      if (in_ready !== exp) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", n, in_ready, exp); end
      tick();
      total++;
      if ({out_valid, busy, illegal} !== {m_full, (m_cnt == DMAX), m_ill}) begin
        bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", n, {out_valid, busy, illegal},
                        {m_full, (m_cnt == DMAX), m_ill});
      end
      if (m_full) begin
        total++;
        if (obs !== m_cmd) begin bad++; $display("FAIL rnd_cmd@%0d: got %h want %h", n, obs, m_cmd); end
      end
    end
    rst = 0;
    idle();
    tick();
  endtask

  initial begin
    rst = 1;
    m_full = 0; m_ill = 0; m_cnt = 0; m_cmd = '0;
    idle();
    test_reset();
    test_mulh();
    test_back_to_back();
    test_div_special();
    test_div_busy();
    test_hold();
    test_illegal();
    test_flush();
    test_xlen32();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/m_issue_unit.md
M_ISSUE_UNIT -- requirements
Module: m_issue_unit

Interface
REQ-001 Parameter XLEN, default 32, operand width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 5, destination-tag width.
REQ-003 Parameter DIV_MAX, default 2, maximum divides in flight; legal range 1..7.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 in_valid_i / in_ready_o  input / output  1 / 1  instruction handshake.
REQ-007 opcode_i, funct3_i, funct7_i  input  7/3/7  instruction fields.
REQ-008 rs1_i, rs2_i  input  XLEN each  operands; tag_i  input  TAG_W  destination tag.
REQ-009 flush_i  input  1  discard the held command.
REQ-010 div_done_i  input  1  one-cycle pulse per completed divide.
REQ-011 out_valid_o / out_ready_i  output / input  1 / 1  command handshake.
REQ-012 mult_on_o, div_on_o, signed_A_o, signed_B_o, upper_rem_o, word_o  output  1 each  registered decode.
REQ-013 div_zero_o, div_ovf_o  output  1 each  registered divide special-case flags.
REQ-014 rs1_o, rs2_o  output  XLEN each; tag_o  output  TAG_W.
REQ-015 illegal_o  output  1  one-cycle pulse on a dropped malformed M instruction.
REQ-016 div_busy_o  output  1  high when the in-flight divide count equals DIV_MAX.

Function
REQ-017 M instruction: opcode 0110011 with funct7 0000001; when XLEN=64, also opcode 0111011 with funct7 0000001 (word_o=1).
REQ-018 funct3 mapping (A,B,upper_rem): 000=(0,0,0), 001=(1,1,1), 010=(1,0,1), 011=(0,0,1), 100=(1,1,0), 101=(0,0,0), 110=(1,1,1), 111=(0,0,1); funct3[2]=0 selects mult, 1 selects div.
REQ-019 Word opcode with funct3 001, 010 or 011: instruction is accepted, not loaded, and illegal_o pulses the next cycle.
REQ-020 Non-M instructions are accepted and dropped, with no output and no illegal_o.
REQ-021 Output register states: EMPTY and FULL; out_valid_o=1 only in FULL.
REQ-022 in_ready_o = !rst_i && !flush_i && (EMPTY || out_ready_i) && !(decoded div && div_busy_o); combinational.
REQ-023 Accepted M instruction loads the register on the same edge: latency 1 cycle, back-to-back throughput 1 per cycle.
REQ-024 FULL with out_ready_i=1 and no new load: next state EMPTY; FULL with out_ready_i=0: all outputs held stable.
REQ-025 div_zero_o=1 for a divide whose divisor is zero: rs2 == 0, or rs2[31:0] == 0 when word_o=1.
REQ-026 div_ovf_o=1 for a signed divide (funct3 100 or 110) with dividend = most-negative value and divisor = all ones, at XLEN bits or 32 bits when word_o=1.
REQ-027 div_zero_o and div_ovf_o are 0 for mult commands.
REQ-028 Divide counter: width ceil(log2(DIV_MAX+1)).
REQ-029 Divide counter next value = count + accepted_div - div_done_i - flushed_div.
REQ-030 Simultaneous accept and done leaves the divide counter unchanged.
REQ-031 The divide counter never underflows: a div_done_i at 0 is ignored.
REQ-032 flush_i: register goes EMPTY next cycle; a flushed held divide decrements the counter.
REQ-033 Precedence: rst_i > flush_i > handshake.

Reset
REQ-034 Reset effect: register EMPTY, counter 0, illegal_o=0.
REQ-035 Reset effect: all decode outputs and flags 0, and rs1_o, rs2_o, tag_o = 0.
REQ-036 Reset mid-operation discards the held command and any pending divide accounting.

Verification
REQ-037 MULH, rs1=0xFFFFFFFF, rs2=2, out_ready_i=1 -> next cycle out_valid_o=1, mult_on_o=1, A=B=upper_rem=1.
REQ-038 DIV with rs1=0x80000000, rs2=0xFFFFFFFF -> div_ovf_o=1, div_zero_o=0; DIVU with rs2=0 -> div_zero_o=1.
REQ-039 DIV_MAX=2, three DIVs, no div_done_i -> third stalled (in_ready_o=0, div_busy_o=1) until a div_done_i pulse, then accepted next cycle.
REQ-040 out_ready_i=0 for 3 cycles holding REMU -> outputs stable, in_ready_o=0; out_ready_i=1 -> a new MUL loads the same edge.
REQ-041 XLEN=64 MULHW encoding (opcode 0111011, funct3 001) -> illegal_o pulse, out_valid_o stays 0.
REQ-042 Held DIV, flush_i and div_done_i in the same cycle (counter 2) -> EMPTY, counter 0.
